ignition_sequencer: RTL and testbench
=====================================

# ignition_sequencer

Downstream consumer of the car safety interlock outputs. Takes the interlock's start-permit, warning and chime-request signals plus driver start-button and engine-running feedback. Sequences ignition power, a timed precheck, a bounded starter crank, run and fault lockout. Also converts the static chime/warning levels into audible beep patterns.

## Interface
Parameters:
- PRECHECK_CYC, default 4: cycles IGN_ON is held before the starter engages.
- CRANK_MAX_CYC, default 20: maximum cycles STARTER may stay high.
- LOCKOUT_CYC, default 50: cycles spent in LOCKOUT after a failed crank.
- CHIME_PERIOD, default 16: fast beep period in cycles; must be even and ≥2.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START_PERMIT  in  1  interlock start permission.
- KEY  in  1  key present.
- BRK  in  1  brake pressed.
- START_BTN  in  1  start/stop button level.
- ENGINE_RUNNING  in  1  engine speed feedback.
- WARN_PRI1  in  1  priority-1 warning.
- WARN_PRI2  in  1  priority-2 warning.
- CHIME_REQ  in  1  chime request from interlock.
- IGN_ON  out  1  ignition relay.
- STARTER  out  1  starter relay.
- ENG_STATE  out  3  current state code.
- FAULT  out  1  high while in LOCKOUT.
- DENY  out  1  one-cycle pulse on a rejected start press.
- CHIME_OUT  out  1  beep drive.

## Operation
- Button edge: BTN_EDGE = START_BTN & !btn_q, with btn_q registered every cycle.
- btn_q resets to 1, so a button held through reset produces no edge.
- States and codes: IDLE=0, PRECHECK=1, CRANK=2, RUN=3, LOCKOUT=4.
- The FSM is Moore: IGN_ON=1 in PRECHECK/CRANK/RUN; STARTER=1 only in CRANK; FAULT=1 only in LOCKOUT.
- IDLE:
  - BTN_EDGE & BRK & START_PERMIT & !WARN_PRI1 → PRECHECK.
  - BTN_EDGE with any of those conditions failing → stay IDLE and pulse DENY.
- PRECHECK:
  - START_PERMIT=0 or KEY=0 → IDLE.
  - Otherwise, after PRECHECK_CYC cycles in the state → CRANK.
- CRANK (priority order, highest first):
  - KEY=0 or START_PERMIT=0 → IDLE.
  - ENGINE_RUNNING=1 → RUN.
  - Crank counter reaches CRANK_MAX_CYC → LOCKOUT.
- RUN (priority order, highest first):
  - KEY=0 → IDLE.
  - ENGINE_RUNNING=0 (stall) → IDLE.
  - BTN_EDGE (stop request) → IDLE.
  - START_PERMIT is ignored in RUN.
- LOCKOUT:
  - BTN_EDGE is ignored.
  - After LOCKOUT_CYC cycles → IDLE.
- The state counter is shared, clears on every state change, and saturates. Its width is clog2 of the largest of the three cycle parameters, plus 1.
- Chime source priority:
  - WARN_PRI1 | CHIME_REQ: fast pattern, high for CHIME_PERIOD/2 then low for CHIME_PERIOD/2.
  - Else WARN_PRI2: slow pattern, period 4·CHIME_PERIOD, high for the first CHIME_PERIOD/2 cycles of each period.
  - Else CHIME_OUT=0.
- The pattern counter restarts at 0 whenever the selected source changes, so each new pattern begins with its high phase.

## Timing
- All outputs are registered or decoded from registers.
- Reset values: state IDLE, IGN_ON=0, STARTER=0, ENG_STATE=0, FAULT=0, DENY=0, CHIME_OUT=0, counters 0.
- An input sampled at edge N changes the state at edge N, so outputs change after that edge (one-cycle latency).
- PRECHECK is entered at edge N and STARTER rises at edge N+PRECHECK_CYC.
- Without running feedback, STARTER stays high for exactly CRANK_MAX_CYC cycles, then FAULT rises.
- FAULT stays high for exactly LOCKOUT_CYC cycles.
- RST asserted in any state returns to IDLE at the next edge, and STARTER drops the same cycle.
- ENGINE_RUNNING and the timeout in the same CRANK cycle → RUN.

## Configuration
- PRI2_START_BLOCK_EN defined:
  - WARN_PRI2=1 is an additional IDLE start-reject condition (DENY pulse).
  - WARN_PRI2=1 also aborts PRECHECK to IDLE.
- Macro undefined: WARN_PRI2 affects only the chime pattern.

## Structure
- Package ignition_pkg holds the state codes, the ENG_STATE width, and the chime source select codes.
- Sub-module chime_pattern_gen takes the source select and CHIME_PERIOD and outputs CHIME_OUT.
- The FSM and shared counter stay in ignition_sequencer.

## Test plan
- Start: BRK=1, START_PERMIT=1, KEY=1, press at cycle 10, ENGINE_RUNNING at cycle 16 → IGN_ON at 11, STARTER over cycles 15–16, RUN with ENG_STATE=3 at 17.
- Rejected press: BRK=0 → DENY high for exactly 1 cycle, ENG_STATE stays 0.
- No-fire: ENGINE_RUNNING held 0 → STARTER high for 20 cycles, FAULT high for 50 cycles, press during LOCKOUT ignored, then IDLE.
- Aborts: KEY drops mid-CRANK → IDLE the next cycle, STARTER=0. RST mid-CRANK → all outputs at reset values.
- Chime: WARN_PRI1=1 → CHIME_OUT 8 high / 8 low. With only WARN_PRI2=1 → 8 high / 56 low. Switching PRI2→PRI1 restarts on a high phase.
- Macro on: WARN_PRI2=1 with a valid press → DENY. Macro off: the same press → PRECHECK.

Source files
------------

// File: rtl/ignition_pkg.sv
// Shared definitions for the ignition sequencer: state codes, ENG_STATE width,
// chime source select codes and a small parameter helper.
package ignition_pkg;

    localparam int ENG_STATE_W = 3;

    localparam logic [ENG_STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ENG_STATE_W-1:0] ST_PRECHECK = 3'd1;
    localparam logic [ENG_STATE_W-1:0] ST_CRANK    = 3'd2;
    localparam logic [ENG_STATE_W-1:0] ST_RUN      = 3'd3;
    localparam logic [ENG_STATE_W-1:0] ST_LOCKOUT  = 3'd4;

    typedef enum logic [1:0] {
        CHIME_NONE = 2'd0,
        CHIME_FAST = 2'd1,
        CHIME_SLOW = 2'd2
    } chime_src_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ignition_sequencer_if.sv
// Signal bundle between the interlock/driver side and the ignition sequencer.
interface ignition_sequencer_if;
    import ignition_pkg::*;

    logic                   START_PERMIT;
    logic                   KEY;
    logic                   BRK;
    logic                   START_BTN;
    logic                   ENGINE_RUNNING;
    logic                   WARN_PRI1;
    logic                   WARN_PRI2;
    logic                   CHIME_REQ;
    logic                   IGN_ON;
    logic                   STARTER;
    logic [ENG_STATE_W-1:0] ENG_STATE;
    logic                   FAULT;
    logic                   DENY;
    logic                   CHIME_OUT;

    modport master (
        output START_PERMIT, KEY, BRK, START_BTN, ENGINE_RUNNING,
        output WARN_PRI1, WARN_PRI2, CHIME_REQ,
        input  IGN_ON, STARTER, ENG_STATE, FAULT, DENY, CHIME_OUT
    );

    modport slave (
        input  START_PERMIT, KEY, BRK, START_BTN, ENGINE_RUNNING,
        input  WARN_PRI1, WARN_PRI2, CHIME_REQ,
        output IGN_ON, STARTER, ENG_STATE, FAULT, DENY, CHIME_OUT
    );

endinterface

// File: rtl/chime_pattern_gen.sv
// Beep pattern generator: fast (half-period on/off) or slow (short beep every
// four periods); the phase restarts on every source change so beeps start high.
module chime_pattern_gen
    import ignition_pkg::*;
#(
    parameter int CHIME_PERIOD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  chime_src_t sel,
    output logic       CHIME_OUT
);

    localparam int SLOW_PERIOD = 4 * CHIME_PERIOD;
    localparam int PH_W        = $clog2(SLOW_PERIOD);
    localparam int HIGH_CYC    = CHIME_PERIOD / 2;

    chime_src_t        src_r;
    logic [PH_W-1:0]   phase_r;
    logic [PH_W-1:0]   phase_nxt_s;
    logic              chime_r;
    logic              chime_nxt_s;

    // Next phase and beep level for the currently selected source
    always_comb begin
        phase_nxt_s = PH_W'(0);
        chime_nxt_s = 1'b0;
        if (sel != src_r) begin
            phase_nxt_s = PH_W'(0);
        end else begin
            case (sel)
                CHIME_FAST: phase_nxt_s = (phase_r == PH_W'(CHIME_PERIOD - 1)) ? PH_W'(0) : phase_r + PH_W'(1);
                CHIME_SLOW: phase_nxt_s = (phase_r == PH_W'(SLOW_PERIOD - 1)) ? PH_W'(0) : phase_r + PH_W'(1);
                default:    phase_nxt_s = PH_W'(0);
            endcase
        end
        case (sel)
            CHIME_FAST, CHIME_SLOW: chime_nxt_s = (phase_nxt_s < PH_W'(HIGH_CYC));
            default:                chime_nxt_s = 1'b0;
        endcase
    end

    // Pattern phase, source tracking and registered beep output
    always_ff @(posedge CLK) begin
        if (RST) begin
            src_r   <= CHIME_NONE;
            phase_r <= PH_W'(0);
            chime_r <= 1'b0;
        end else begin
            src_r   <= sel;
            phase_r <= phase_nxt_s;
            chime_r <= chime_nxt_s;
        end
    end

    assign CHIME_OUT = chime_r;

endmodule

// File: rtl/ignition_sequencer.sv
// Ignition sequencer: IDLE/PRECHECK/CRANK/RUN/LOCKOUT with one shared counter.
// Define PRI2_START_BLOCK_EN to make WARN_PRI2 reject starts and abort PRECHECK.
module ignition_sequencer
    import ignition_pkg::*;
#(
    parameter int PRECHECK_CYC  = 4,
    parameter int CRANK_MAX_CYC = 20,
    parameter int LOCKOUT_CYC   = 50,
    parameter int CHIME_PERIOD  = 16
) (
    input logic                 CLK,
    input logic                 RST,
    ignition_sequencer_if.slave ign
);

    localparam int CNT_W = $clog2(max3(PRECHECK_CYC, CRANK_MAX_CYC, LOCKOUT_CYC)) + 1;

    logic [ENG_STATE_W-1:0] state_r;
    logic [ENG_STATE_W-1:0] state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   btn_q_r;
    logic                   btn_edge_s;
    logic                   start_ok_s;
    logic                   pre_abort_s;
    logic                   deny_nxt_s;
    logic                   ign_on_r;
    logic                   starter_r;
    logic                   fault_r;
    logic                   deny_r;
    chime_src_t             chime_src_s;
    logic                   chime_out_s;

    assign btn_edge_s = ign.START_BTN & ~btn_q_r;

`ifdef PRI2_START_BLOCK_EN
    assign start_ok_s  = ign.BRK & ign.START_PERMIT & ~ign.WARN_PRI1 & ~ign.WARN_PRI2;
    assign pre_abort_s = ~ign.START_PERMIT | ~ign.KEY | ign.WARN_PRI2;
`else
    assign start_ok_s  = ign.BRK & ign.START_PERMIT & ~ign.WARN_PRI1;
    assign pre_abort_s = ~ign.START_PERMIT | ~ign.KEY;
`endif

    // Next-state decision; counter compares use "cycles already spent minus one"
    always_comb begin
        state_nxt_s = state_r;
        deny_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_edge_s) begin
                    if (start_ok_s) begin
                        state_nxt_s = ST_PRECHECK;
                    end else begin
                        deny_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRECHECK: begin
                if (pre_abort_s)                                  state_nxt_s = ST_IDLE;
                else if (cnt_r == CNT_W'(PRECHECK_CYC - 1))       state_nxt_s = ST_CRANK;
                else                                              state_nxt_s = ST_PRECHECK;
            end
            ST_CRANK: begin
                if (!ign.KEY || !ign.START_PERMIT)                state_nxt_s = ST_IDLE;
                else if (ign.ENGINE_RUNNING)                      state_nxt_s = ST_RUN;
                else if (cnt_r == CNT_W'(CRANK_MAX_CYC - 1))      state_nxt_s = ST_LOCKOUT;
                else                                              state_nxt_s = ST_CRANK;
            end
            ST_RUN: begin
                if (!ign.KEY)                                     state_nxt_s = ST_IDLE;
                else if (!ign.ENGINE_RUNNING)                     state_nxt_s = ST_IDLE;
                else if (btn_edge_s)                              state_nxt_s = ST_IDLE;
                else                                              state_nxt_s = ST_RUN;
            end
            ST_LOCKOUT: begin
                if (cnt_r == CNT_W'(LOCKOUT_CYC - 1))             state_nxt_s = ST_IDLE;
                else                                              state_nxt_s = ST_LOCKOUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, shared saturating counter, button history and registered Moore outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_W'(0);
            btn_q_r   <= 1'b1;
            ign_on_r  <= 1'b0;
            starter_r <= 1'b0;
            fault_r   <= 1'b0;
            deny_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            btn_q_r <= ign.START_BTN;
            if (state_nxt_s != state_r) begin
                cnt_r <= CNT_W'(0);
            end else if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            ign_on_r  <= (state_nxt_s == ST_PRECHECK) || (state_nxt_s == ST_CRANK) ||
                         (state_nxt_s == ST_RUN);
            starter_r <= (state_nxt_s == ST_CRANK);
            fault_r   <= (state_nxt_s == ST_LOCKOUT);
            deny_r    <= deny_nxt_s;
        end
    end

    // Chime source priority: urgent (fast) over priority-2 (slow) over silence
    always_comb begin
        chime_src_s = CHIME_NONE;
        if (ign.WARN_PRI1 || ign.CHIME_REQ) begin
            chime_src_s = CHIME_FAST;
        end else if (ign.WARN_PRI2) begin
            chime_src_s = CHIME_SLOW;
        end else begin
            chime_src_s = CHIME_NONE;
        end
    end

    chime_pattern_gen #(
        .CHIME_PERIOD (CHIME_PERIOD)
    ) u_chime (
        .CLK       (CLK),
        .RST       (RST),
        .sel       (chime_src_s),
        .CHIME_OUT (chime_out_s)
    );

    assign ign.IGN_ON    = ign_on_r;
    assign ign.STARTER   = starter_r;
    assign ign.ENG_STATE = state_r;
    assign ign.FAULT     = fault_r;
    assign ign.DENY      = deny_r;
    assign ign.CHIME_OUT = chime_out_s;

endmodule

// File: tb/tb_ignition_sequencer.sv
// Self-checking bench for ignition_sequencer: cycle model plus literal run-length checks.
module tb_ignition_sequencer;

    localparam int P_PRE   = 4;
    localparam int P_CRANK = 20;
    localparam int P_LOCK  = 50;
    localparam int P_CHIME = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    ignition_sequencer_if ifc();

    ignition_sequencer #(
        .PRECHECK_CYC  (P_PRE),
        .CRANK_MAX_CYC (P_CRANK),
        .LOCKOUT_CYC   (P_LOCK),
        .CHIME_PERIOD  (P_CHIME)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .ign (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: mode code, cycles spent in mode, chime source and its age
    int m_mode = 0, m_age = 0, m_src = 0, m_cage = 0, m_next = 0, m_nsrc = 0;
    bit m_btn_prev = 1'b1, m_deny = 1'b0, m_press = 1'b0, m_ok = 1'b0, m_pre_abort = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_age = 0; m_btn_prev = 1'b1; m_deny = 1'b0; m_src = 0; m_cage = 0;
        end else begin
            m_press = ifc.START_BTN && !m_btn_prev;
            m_btn_prev = ifc.START_BTN;
            m_ok = ifc.BRK && ifc.START_PERMIT && !ifc.WARN_PRI1;
            m_pre_abort = !ifc.START_PERMIT || !ifc.KEY;
`ifdef PRI2_START_BLOCK_EN
            m_ok = m_ok && !ifc.WARN_PRI2;
            m_pre_abort = m_pre_abort || ifc.WARN_PRI2;
`endif
            m_next = m_mode;
            m_deny = 1'b0;
            if (m_mode == 0 && m_press) begin
                if (m_ok) m_next = 1; else m_deny = 1'b1;
            end else if (m_mode == 1) begin
                if (m_pre_abort) m_next = 0;
                else if (m_age + 1 >= P_PRE) m_next = 2;
            end else if (m_mode == 2) begin
                if (!ifc.KEY || !ifc.START_PERMIT) m_next = 0;
                else if (ifc.ENGINE_RUNNING) m_next = 3;
                else if (m_age + 1 >= P_CRANK) m_next = 4;
            end else if (m_mode == 3) begin
                if (!ifc.KEY || !ifc.ENGINE_RUNNING || m_press) m_next = 0;
            end else if (m_mode == 4) begin
                if (m_age + 1 >= P_LOCK) m_next = 0;
            end
            if (m_next != m_mode) m_age = 0; else m_age = m_age + 1;
            m_mode = m_next;
            m_nsrc = (ifc.WARN_PRI1 || ifc.CHIME_REQ) ? 1 : (ifc.WARN_PRI2 ? 2 : 0);
            if (m_nsrc != m_src) m_cage = 0; else m_cage = m_cage + 1;
            m_src = m_nsrc;
        end
    end

    function automatic int exp_vec();
        bit ch;
        ch = (m_src == 1) ? ((m_cage % P_CHIME) < P_CHIME / 2) :
             (m_src == 2) ? ((m_cage % (4 * P_CHIME)) < P_CHIME / 2) : 1'b0;
        return {24'd0, (m_mode >= 1 && m_mode <= 3), (m_mode == 2), m_mode[2:0],
                (m_mode == 4), m_deny, ch};
    endfunction

    function automatic int dut_vec();
        return {24'd0, ifc.IGN_ON, ifc.STARTER, ifc.ENG_STATE, ifc.FAULT, ifc.DENY, ifc.CHIME_OUT};
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) check("cyc_outputs", dut_vec(), exp_vec());
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return ifc.STARTER;
            1:       return ifc.FAULT;
            default: return ifc.CHIME_OUT;
        endcase
    endfunction

    task automatic run_len(input int which, input logic val, output int n);
        n = 0;
        while (sig(which) == val && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic press();
        ifc.START_BTN = 1'b1;
        @(negedge clk);
        ifc.START_BTN = 1'b0;
    endtask

    task automatic wait_starter(output int k);
        k = 0;
        while (!ifc.STARTER && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    int n;

    initial begin
        ifc.START_PERMIT = 1'b1; ifc.KEY = 1'b1; ifc.BRK = 1'b1; ifc.START_BTN = 1'b0;
        ifc.ENGINE_RUNNING = 1'b0; ifc.WARN_PRI1 = 1'b0; ifc.WARN_PRI2 = 1'b0; ifc.CHIME_REQ = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_vec(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Normal start then stop from RUN
        press();
        check("start_state", ifc.ENG_STATE, 1);
        check("start_ign", ifc.IGN_ON, 1);
        wait_starter(n);
        check("precheck_len", n, 4);
        @(negedge clk);
        ifc.ENGINE_RUNNING = 1'b1;
        @(negedge clk);
        check("run_state", ifc.ENG_STATE, 3);
        check("run_starter", ifc.STARTER, 0);
        press();
        check("stop_state", ifc.ENG_STATE, 0);
        ifc.ENGINE_RUNNING = 1'b0;
        @(negedge clk);

        // Rejected press without brake
        ifc.BRK = 1'b0;
        press();
        check("deny_pulse", ifc.DENY, 1);
        check("deny_state", ifc.ENG_STATE, 0);
        @(negedge clk);
        check("deny_width", ifc.DENY, 0);
        ifc.BRK = 1'b1;
        @(negedge clk);

        // No-fire: crank timeout then lockout, press ignored during lockout
        press();
        wait_starter(n);
        run_len(0, 1'b1, n);
        check("crank_len", n, 20);
        n = 0;
        while (ifc.FAULT && n < 200) begin
            n++;
            if (n == 10) ifc.START_BTN = 1'b1;
            if (n == 12) ifc.START_BTN = 1'b0;
            @(negedge clk);
        end
        check("lockout_len", n, 50);
        check("after_lockout", ifc.ENG_STATE, 0);
        @(negedge clk);

        // Key pulled mid-crank
        press();
        wait_starter(n);
        repeat (2) @(negedge clk);
        ifc.KEY = 1'b0;
        @(negedge clk);
        check("key_abort_state", ifc.ENG_STATE, 0);
        check("key_abort_starter", ifc.STARTER, 0);
        ifc.KEY = 1'b1;
        @(negedge clk);

        // Reset mid-crank
        press();
        wait_starter(n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_crank", dut_vec(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Chime patterns
        ifc.WARN_PRI1 = 1'b1;
        @(negedge clk);
        run_len(2, 1'b1, n); check("fast_high", n, 8);
        run_len(2, 1'b0, n); check("fast_low", n, 8);
        ifc.WARN_PRI1 = 1'b0; ifc.WARN_PRI2 = 1'b1;
        @(negedge clk);
        run_len(2, 1'b1, n); check("slow_high", n, 8);
        run_len(2, 1'b0, n); check("slow_low", n, 56);
        repeat (10) @(negedge clk);
        check("slow_in_low", ifc.CHIME_OUT, 0);
        ifc.WARN_PRI1 = 1'b1;
        @(negedge clk);
        check("switch_high", ifc.CHIME_OUT, 1);
        run_len(2, 1'b1, n); check("switch_high_len", n, 8);
        ifc.WARN_PRI1 = 1'b0;

        // Priority-2 warning with a valid press (WARN_PRI2 still high)
        @(negedge clk);
        press();
`ifdef PRI2_START_BLOCK_EN
        check("pri2_deny", ifc.DENY, 1);
        check("pri2_state", ifc.ENG_STATE, 0);
`else
        check("pri2_deny", ifc.DENY, 0);
        check("pri2_state", ifc.ENG_STATE, 1);
`endif
        repeat (3) @(negedge clk);
        ifc.WARN_PRI2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
